// File: rtl/cadence_gen_if.sv
// ---------------------------------------------------------------------------
// cadence_gen_if
//   Bundles the control inputs and the sensor-side outputs of cadence_gen.
//   master : stimulus/controller side (drives run and bounce settings)
//   slave  : cadence_gen side (drives the generated waveform and counters)
//
//   en            run request; 0 parks the output low
//   half_per      cycles per clean high or low level
//   bounce_en     enable glitch injection after each clean edge
//   bounce_gap    glitch width in cycles (also the gap between glitches)
//   bounce_cnt    glitches injected per clean edge
//   cadence       bouncy sensor output (feeds the conditioning filter)
//   cadence_clean ideal square wave
//   rise_pulse    1-cycle strobe on each cadence_clean rise
//   rev_cnt       count of cadence_clean rises (wraps)
// ---------------------------------------------------------------------------
interface cadence_gen_if #(
   parameter int PER_W = 24,
   parameter int GAP_W = 8,
   parameter int BNC_W = 4
);
   logic             en;
   logic [PER_W-1:0] half_per;
   logic             bounce_en;
   logic [GAP_W-1:0] bounce_gap;
   logic [BNC_W-1:0] bounce_cnt;
   logic             cadence;
   logic             cadence_clean;
   logic             rise_pulse;
   logic [15:0]      rev_cnt;

   modport master (
      output en, half_per, bounce_en, bounce_gap, bounce_cnt,
      input  cadence, cadence_clean, rise_pulse, rev_cnt
   );

   modport slave (
      input  en, half_per, bounce_en, bounce_gap, bounce_cnt,
      output cadence, cadence_clean, rise_pulse, rev_cnt
   );
endinterface

// File: rtl/cadence_gen.sv
// ---------------------------------------------------------------------------
// cadence_gen
//   Pedal-cadence source standing in for the physical pedal sensor. Emits a
//   square wave with a programmable half-period and optional contact bounce
//   (a burst of inverted pulses) right after each clean edge.
//
//   clk    system clock
//   rst_n  asynchronous reset, active-low
//   bus    cadence_gen_if.slave: en, half_per, bounce_en, bounce_gap,
//          bounce_cnt in; cadence, cadence_clean, rise_pulse, rev_cnt out
// ---------------------------------------------------------------------------
module cadence_gen #(
   parameter int PER_W = 24,
   parameter int GAP_W = 8,
   parameter int BNC_W = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   cadence_gen_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           r_state;
   logic [PER_W-1:0] r_hp;         // effective half-period of current level
   logic [PER_W-1:0] r_lvl_cnt;    // cycles spent in current level, 1-based
   logic             r_clean;
   logic             r_cadence;
   logic             r_rise;
   logic [15:0]      r_rev_cnt;
   logic             r_b_run;      // bounce burst in progress
   logic [GAP_W-1:0] r_b_gap;
   logic [GAP_W-1:0] r_b_ph;       // cycles left in current glitch phase
   logic [BNC_W:0]   r_b_halves;   // glitch phases (high + low) still to run

   logic [PER_W-1:0] w_eff_hp;
   logic             w_bounce_ok;
   logic             w_lvl_done;
   logic             w_rise;
   logic             w_fall;

   // NOTE: every always_comb output is assigned on every path, so no latches.
   always_comb begin
      w_eff_hp    = (bus.half_per < PER_W'(2)) ? PER_W'(2) : bus.half_per;
      // The burst must end strictly inside the level it follows.
      w_bounce_ok = bus.bounce_en && (bus.bounce_cnt != '0) && (bus.bounce_gap != '0) &&
                    ({32'(bus.bounce_cnt) * 32'(bus.bounce_gap), 1'b0} < 33'(w_eff_hp));
      w_lvl_done  = (r_lvl_cnt == r_hp);
      w_rise      = bus.en && ((r_state == IDLE) || ((r_state == LOW) && w_lvl_done));
      w_fall      = (r_state == HIGH) && w_lvl_done;
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // right-hand side below sees the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hp       <= '0;
         r_lvl_cnt  <= '0;
         r_clean    <= 1'b0;
         r_cadence  <= 1'b0;
         r_rise     <= 1'b0;
         r_rev_cnt  <= '0;
         r_b_run    <= 1'b0;
         r_b_gap    <= '0;
         r_b_ph     <= '0;
         r_b_halves <= '0;
      end else begin
         r_rise <= w_rise;
         if (w_rise) r_rev_cnt <= r_rev_cnt + 16'd1;

         if (w_rise || w_fall) begin
            // Clean edge: latch half-period and bounce settings for this level.
            r_clean    <= w_rise;
            r_cadence  <= w_rise;
            r_hp       <= w_eff_hp;
            r_lvl_cnt  <= PER_W'(1);
            r_b_gap    <= bus.bounce_gap;
            r_b_ph     <= '0;
            r_b_halves <= {bus.bounce_cnt, 1'b0};
            if (w_rise) begin
               r_state <= HIGH;
               r_b_run <= w_bounce_ok;
            end else if (bus.en) begin
               r_state <= LOW;
               r_b_run <= w_bounce_ok;
            end else begin
               // High level finished with run dropped: park, no bounce.
               r_state <= IDLE;
               r_b_run <= 1'b0;
            end
         end else if ((r_state == LOW) && !bus.en) begin
            // Leaving LOW truncates any burst; output parks low.
            r_state   <= IDLE;
            r_b_run   <= 1'b0;
            r_cadence <= 1'b0;
         end else begin
            if (r_state != IDLE) r_lvl_cnt <= r_lvl_cnt + PER_W'(1);
            if (r_b_run) begin
               if (r_b_ph == '0) begin
                  if (r_b_halves == '0) begin
                     r_b_run <= 1'b0;
                  end else begin
                     // Each phase boundary flips the glitch, hence the output.
                     r_cadence  <= ~r_cadence;
                     r_b_ph     <= r_b_gap - GAP_W'(1);
                     r_b_halves <= r_b_halves - (BNC_W+1)'(1);
                  end
               end else begin
                  r_b_ph <= r_b_ph - GAP_W'(1);
               end
            end
         end
      end
   end

   assign bus.cadence       = r_cadence;
   assign bus.cadence_clean = r_clean;
   assign bus.rise_pulse    = r_rise;
   assign bus.rev_cnt       = r_rev_cnt;

endmodule

// File: tb/tb_cadence_gen.sv
// ---------------------------------------------------------------------------
// tb_cadence_gen
//   Directed bench for cadence_gen. All sampling and driving happens 1 ns
//   after the rising edge. Cycle index k = 0 is the cycle right after the
//   edge that first samples en=1 (clean just rose).
// ---------------------------------------------------------------------------
module tb_cadence_gen;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   cadence_gen_if bus_if ();

   cadence_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n               = 1'b0;
      bus_if.en           = 1'b0;
      bus_if.half_per     = 24'd10;
      bus_if.bounce_en    = 1'b0;
      bus_if.bounce_gap   = 8'd0;
      bus_if.bounce_cnt   = 4'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle k=%0d: got cad=%b clean=%b rise=%b rev=%h, want all 0",
                     k, bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt);
         end
         step();
      end
   endtask

   task automatic test_basic();
      apply_reset();
      bus_if.half_per = 24'd10;
      bus_if.en       = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         checks++;
         if (bus_if.cadence_clean !== ((k % 20) < 10)) begin
            errors++;
            $display("FAIL basic_clean k=%0d: got %b want %b", k, bus_if.cadence_clean, (k % 20) < 10);
         end
         checks++;
         if (bus_if.cadence !== bus_if.cadence_clean || bus_if.cadence !== ((k % 20) < 10)) begin
            errors++;
            $display("FAIL basic_cadence k=%0d: got %b want %b", k, bus_if.cadence, (k % 20) < 10);
         end
         checks++;
         if (bus_if.rise_pulse !== ((k % 20) == 0)) begin
            errors++;
            $display("FAIL basic_rise k=%0d: got %b want %b", k, bus_if.rise_pulse, (k % 20) == 0);
         end
         if (k == 80 || k == 99) begin
            checks++;
            if (bus_if.rev_cnt !== 16'd5) begin
               errors++;
               $display("FAIL basic_rev k=%0d: got %0d want 5", k, bus_if.rev_cnt);
            end
         end
      end
   endtask

   task automatic test_min_period(input logic [23:0] hp);
      apply_reset();
      bus_if.half_per = hp;
      bus_if.en       = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         checks++;
         if (bus_if.cadence_clean !== ((k % 4) < 2) || bus_if.rise_pulse !== ((k % 4) == 0)) begin
            errors++;
            $display("FAIL min_period hp=%0d k=%0d: got clean=%b rise=%b want clean=%b rise=%b",
                     hp, k, bus_if.cadence_clean, bus_if.rise_pulse, (k % 4) < 2, (k % 4) == 0);
         end
      end
      checks++;
      if (bus_if.rev_cnt !== 16'd4) begin
         errors++;
         $display("FAIL min_period_rev hp=%0d: got %0d want 4", hp, bus_if.rev_cnt);
      end
   endtask

   // gap=3, cnt=2: glitch at offsets 1..3 and 7..9 after every clean edge
   // when 12 < hp, otherwise never.
   task automatic test_bounce(input int hp, input logic exp_glitch);
      logic exp_clean;
      logic exp_g;
      int   off;
      apply_reset();
      bus_if.half_per   = 24'(hp);
      bus_if.bounce_en  = 1'b1;
      bus_if.bounce_gap = 8'd3;
      bus_if.bounce_cnt = 4'd2;
      bus_if.en         = 1'b1;
      for (int k = 0; k < 2 * hp + 12; k++) begin
         step();
         exp_clean = ((k % (2 * hp)) < hp);
         off       = k % hp;
         exp_g     = exp_glitch && (((off >= 1) && (off <= 3)) || ((off >= 7) && (off <= 9)));
         checks++;
         if (bus_if.cadence_clean !== exp_clean || bus_if.cadence !== (exp_clean ^ exp_g)) begin
            errors++;
            $display("FAIL bounce hp=%0d k=%0d: got clean=%b cad=%b want clean=%b cad=%b",
                     hp, k, bus_if.cadence_clean, bus_if.cadence, exp_clean, exp_clean ^ exp_g);
         end
      end
   endtask

   task automatic test_hp_change();
      logic exp_clean;
      apply_reset();
      bus_if.half_per = 24'd10;
      bus_if.en       = 1'b1;
      for (int k = 0; k < 90; k++) begin
         step();
         exp_clean = (k < 10) || ((k >= 40) && (k < 70));
         checks++;
         if (bus_if.cadence_clean !== exp_clean || bus_if.cadence !== exp_clean ||
             bus_if.rise_pulse !== ((k == 0) || (k == 40))) begin
            errors++;
            $display("FAIL hp_change k=%0d: got clean=%b cad=%b rise=%b want clean=%b rise=%b",
                     k, bus_if.cadence_clean, bus_if.cadence, bus_if.rise_pulse,
                     exp_clean, (k == 0) || (k == 40));
         end
         if (k == 4)  bus_if.half_per = 24'd30;
         if (k == 50) bus_if.en = 1'b0;
      end
      checks++;
      if (bus_if.rev_cnt !== 16'd2) begin
         errors++;
         $display("FAIL hp_change_rev: got %0d want 2", bus_if.rev_cnt);
      end
   endtask

   // Drop en in LOW while a burst (gap=1, cnt=2) is running: IDLE next
   // cycle, and the glitch that was due at offset 3 never appears.
   task automatic test_low_drop();
      apply_reset();
      bus_if.half_per   = 24'd10;
      bus_if.bounce_en  = 1'b1;
      bus_if.bounce_gap = 8'd1;
      bus_if.bounce_cnt = 4'd2;
      bus_if.en         = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         if (k == 11) begin
            checks++;
            if (bus_if.cadence !== 1'b1 || bus_if.cadence_clean !== 1'b0) begin
               errors++;
               $display("FAIL low_drop_glitch: got cad=%b clean=%b want cad=1 clean=0",
                        bus_if.cadence, bus_if.cadence_clean);
            end
            bus_if.en = 1'b0;
         end
         if (k >= 12) begin
            checks++;
            if (bus_if.cadence !== 1'b0 || bus_if.cadence_clean !== 1'b0 || bus_if.rise_pulse !== 1'b0) begin
               errors++;
               $display("FAIL low_drop_idle k=%0d: got cad=%b clean=%b rise=%b want 0 0 0",
                        k, bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse);
            end
         end
      end
   endtask

   task automatic test_wrap_and_reset();
      apply_reset();
      bus_if.half_per = 24'd0;
      bus_if.en       = 1'b1;
      step();   // k=0 rise
      step();   // k=1
      step();   // k=2, low
      force dut.r_rev_cnt = 16'hFFFF;
      #1;
      release dut.r_rev_cnt;
      step();   // k=3
      checks++;
      if (bus_if.rev_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_hold: got %h want ffff", bus_if.rev_cnt);
      end
      step();   // k=4 rise
      checks++;
      if (bus_if.rev_cnt !== 16'h0000 || bus_if.rise_pulse !== 1'b1) begin
         errors++;
         $display("FAIL wrap: got rev=%h rise=%b want rev=0000 rise=1", bus_if.rev_cnt, bus_if.rise_pulse);
      end

      // Reset in the middle of a glitch.
      apply_reset();
      bus_if.half_per   = 24'd100;
      bus_if.bounce_en  = 1'b1;
      bus_if.bounce_gap = 8'd3;
      bus_if.bounce_cnt = 4'd2;
      bus_if.en         = 1'b1;
      step();   // k=0
      step();   // k=1, glitch active
      checks++;
      if (bus_if.cadence !== 1'b0 || bus_if.cadence_clean !== 1'b1 || bus_if.rev_cnt !== 16'd1) begin
         errors++;
         $display("FAIL pre_reset_glitch: got cad=%b clean=%b rev=%0d want 0 1 1",
                  bus_if.cadence, bus_if.cadence_clean, bus_if.rev_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt} !== 19'd0) begin
         errors++;
         $display("FAIL async_reset: got cad=%b clean=%b rise=%b rev=%h want all 0",
                  bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt);
      end
      step();
      step();
      checks++;
      if ({bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt} !== 19'd0) begin
         errors++;
         $display("FAIL reset_held: got cad=%b clean=%b rise=%b rev=%h want all 0",
                  bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt);
      end
      rst_n = 1'b1;
      step();   // fresh rise, no glitch yet
      checks++;
      if (bus_if.cadence !== 1'b1 || bus_if.cadence_clean !== 1'b1 ||
          bus_if.rise_pulse !== 1'b1 || bus_if.rev_cnt !== 16'd1) begin
         errors++;
         $display("FAIL restart: got cad=%b clean=%b rise=%b rev=%0d want 1 1 1 1",
                  bus_if.cadence, bus_if.cadence_clean, bus_if.rise_pulse, bus_if.rev_cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_min_period(24'd0);
      test_min_period(24'd1);
      test_bounce(100, 1'b1);
      test_bounce(10, 1'b0);
      test_bounce(12, 1'b0);
      test_bounce(13, 1'b1);
      test_hp_change();
      test_low_drop();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
